same_reader: RTL and testbench

SAME_READER -- requirements
Module: same_reader

---
 rtl/same_reader_pkg.sv | 26 ++
 rtl/same_reader_fifo.sv | 54 +++++
 rtl/same_reader.sv | 110 +++++++++++
 tb/tb_same_reader.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/same_reader_pkg.sv
// Shared widths, FSM encoding and the "same" window start-offset helper
// for the same_reader convolution window extractor.
package same_reader_pkg;

    localparam int unsigned SR_DATA_W = 16;
    localparam int unsigned SR_ADDR_W = 6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    // Centre the window inside the full convolution: (size_y-1)>>1, 0 for an empty kernel.
    function automatic logic [SR_ADDR_W-1:0] calc_off(input logic [4:0] size_y);
        logic [SR_ADDR_W-1:0] y;
        y = SR_ADDR_W'(size_y);
        if (y == '0) begin
            return '0;
        end
        return (y - 1'b1) >> 1;
    endfunction

endpackage

// File: rtl/same_reader_fifo.sv
// Two-entry show-ahead FIFO buffering memory read data toward the output stream.
module same_reader_fifo
    import same_reader_pkg::*;
#(
    parameter int unsigned DATA_W = SR_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              valid,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count_q;
    logic              do_pop;

    always_comb begin
        do_pop = pop && (count_q != 2'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0]  <= '0;
            mem[1]  <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, do_pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign valid = (count_q != 2'd0);
    assign count = count_q;

endmodule

// File: rtl/same_reader.sv
// Streams the size_x-long "same" window out of a full-convolution result memory,
// with one-cycle read latency absorbed by a 2-entry FIFO under output backpressure.
module same_reader
    import same_reader_pkg::*;
#(
    parameter int unsigned DATA_W = SR_DATA_W,
    parameter int unsigned ADDR_W = SR_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [4:0]        size_x_i,
    input  logic [4:0]        size_y_i,
    output logic              memz_rd_o,
    output logic [ADDR_W-1:0] memz_addr_o,
    input  logic [DATA_W-1:0] memz_data_i,
    output logic [DATA_W-1:0] dout_o,
    output logic              dout_valid_o,
    input  logic              dout_ready_i,
    output logic              busy_o,
    output logic              done_o
);

    state_t            state_q;
    logic [4:0]        size_x_q;
    logic [4:0]        size_y_q;
    logic [4:0]        remaining_q;
    logic [ADDR_W-1:0] addr_q;
    logic              pend_q;
    logic              done_q;
    logic [1:0]        fifo_count;
    logic              pop;
    logic              rd;
    logic [2:0]        credit;

    // The pop in this cycle frees a slot before the pending read lands, which
    // is what allows one sample per cycle through only two FIFO entries.
    always_comb begin
        pop    = dout_valid_o && dout_ready_i;
        credit = 3'(fifo_count) + 3'(pend_q) - 3'(pop);
        rd     = (state_q == S_READ) && (remaining_q != 5'd0) && (credit < 3'd2);
    end

    same_reader_fifo #(.DATA_W(DATA_W)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (pend_q),
        .push_data (memz_data_i),
        .pop       (pop),
        .head      (dout_o),
        .valid     (dout_valid_o),
        .count     (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            size_x_q    <= '0;
            size_y_q    <= '0;
            remaining_q <= '0;
            addr_q      <= '0;
            pend_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            pend_q <= rd;
            done_q <= (state_q == S_DONE);
            case (state_q)
                S_IDLE: begin
                    // The done pulse cycle still reports busy, so starts are refused there too.
                    if (start_i && !done_q) begin
                        size_x_q <= size_x_i;
                        size_y_q <= size_y_i;
                        state_q  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    addr_q      <= ADDR_W'(calc_off(size_y_q));
                    remaining_q <= size_x_q;
                    state_q     <= (size_x_q == 5'd0) ? S_DONE : S_READ;
                end
                S_READ: begin
                    if (rd) begin
                        addr_q      <= addr_q + 1'b1;
                        remaining_q <= remaining_q - 1'b1;
                        if (remaining_q == 5'd1) begin
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (!pend_q && (fifo_count == 2'd0)) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign memz_rd_o   = rd;
    assign memz_addr_o = addr_q;
    assign busy_o      = (state_q != S_IDLE) || done_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_same_reader.sv
// Randomised and directed bench for same_reader against a queue-based window model.
module tb_same_reader;

    localparam int DW = 16;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [4:0]    size_x;
    logic [4:0]    size_y;
    logic          memz_rd;
    logic [AW-1:0] memz_addr;
    logic [DW-1:0] memz_data;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          ready;
    logic          busy;
    logic          done;

    logic [DW-1:0] mem [64];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [DW-1:0] got_q [$];
    logic [DW-1:0] exp_q [$];
    int            rd_addr_q [$];
    int            exp_addr_q [$];
    int            acc_cyc_q [$];
    int rd_total, acc_total, max_out, stab_err, done_cnt, done_edge;
    int first_valid_edge, start_edge;
    bit seen_valid, held_v;
    logic [DW-1:0] held_d;

    always #5 clk = ~clk;

    same_reader #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start),
        .size_x_i     (size_x),
        .size_y_i     (size_y),
        .memz_rd_o    (memz_rd),
        .memz_addr_o  (memz_addr),
        .memz_data_i  (memz_data),
        .dout_o       (dout),
        .dout_valid_o (dout_valid),
        .dout_ready_i (ready),
        .busy_o       (busy),
        .done_o       (done)
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (memz_rd) memz_data <= mem[memz_addr];
    end

    always @(negedge clk) begin
        if (rst) begin
            held_v = 1'b0;
        end else begin
            if (memz_rd) begin
                rd_addr_q.push_back(int'(memz_addr));
                rd_total++;
            end
            if (dout_valid && !seen_valid) begin
                seen_valid       = 1'b1;
                first_valid_edge = cyc;
            end
            if (dout_valid && ready) begin
                got_q.push_back(dout);
                acc_cyc_q.push_back(cyc);
                acc_total++;
            end
            if (held_v && (!dout_valid || dout !== held_d)) stab_err++;
            held_v = dout_valid && !ready;
            held_d = dout;
            if (rd_total - acc_total > max_out) max_out = rd_total - acc_total;
            if (done) begin
                done_cnt++;
                done_edge = cyc;
            end
        end
    end

    task automatic clear_mon();
        got_q.delete(); exp_q.delete(); rd_addr_q.delete(); exp_addr_q.delete(); acc_cyc_q.delete();
        rd_total = 0; acc_total = 0; max_out = 0; stab_err = 0; done_cnt = 0; done_edge = -1;
        first_valid_edge = -1; start_edge = -1; seen_valid = 1'b0; held_v = 1'b0;
    endtask

    task automatic fill_linear();
        for (int i = 0; i < 64; i++) mem[i] = 16'(i);
    endtask

    // Expected stream: the size_x memory words starting at the centring offset.
    task automatic build_expect(input int sx, input int sy);
        int off;
        off = (sy == 0) ? 0 : (sy - 1) / 2;
        exp_q.delete(); exp_addr_q.delete();
        for (int k = 0; k < sx; k++) begin
            exp_q.push_back(mem[off + k]);
            exp_addr_q.push_back(off + k);
        end
    endtask

    function automatic int first_diff();
        if (got_q.size() != exp_q.size()) return 0;
        foreach (exp_q[i]) if (got_q[i] !== exp_q[i]) return i;
        return -1;
    endfunction

    function automatic int first_addr_diff();
        if (rd_addr_q.size() != exp_addr_q.size()) return 0;
        foreach (exp_addr_q[i]) if (rd_addr_q[i] != exp_addr_q[i]) return i;
        return -1;
    endfunction

    task automatic drive_ready(input int mode, input int c);
        case (mode)
            1:       ready = (c % 2 == 0);
            2:       ready = 1'($urandom_range(0, 1));
            3:       ready = (c >= 10);
            default: ready = 1'b1;
        endcase
    endtask

    task automatic run_req(input int sx, input int sy, input int mode, input int extra_at, output bit ok);
        clear_mon();
        build_expect(sx, sy);
        @(posedge clk); #1;
        size_x = 5'(sx); size_y = 5'(sy); start = 1'b1;
        drive_ready(mode, 0);
        ok = 1'b0;
        for (int c = 1; c <= 400; c++) begin
            @(posedge clk); #1;
            if (c == 1) start_edge = cyc;
            start = (c == extra_at);
            if (c == extra_at) begin size_x = 5'd9; size_y = 5'd9; end
            drive_ready(mode, c);
            @(negedge clk);
            if (done) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; ready = 1'b0; size_x = '0; size_y = '0; memz_data = '0;
        fill_linear();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({memz_rd, memz_addr, dout, dout_valid, busy, done} !== '0) begin
            bad++;
            $display("FAIL reset_outputs rd=%b addr=%0d dout=%0d v=%b busy=%b done=%b required all 0",
                     memz_rd, memz_addr, dout, dout_valid, busy, done);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        bit ok; int d; bit gap;
        fill_linear();
        run_req(4, 3, 0, -1, ok);
        total++; if (!ok) begin bad++; $display("FAIL basic_timeout done never seen"); end
        d = first_diff();
        total++; if (d >= 0) begin bad++; $display("FAIL basic_data n=%0d required n=%0d at idx %0d", got_q.size(), exp_q.size(), d); end
        d = first_addr_diff();
        total++; if (d >= 0) begin bad++; $display("FAIL basic_addr n=%0d required n=%0d at idx %0d", rd_addr_q.size(), exp_addr_q.size(), d); end
        gap = 1'b0;
        foreach (acc_cyc_q[i]) if (acc_cyc_q[i] != acc_cyc_q[0] + i) gap = 1'b1;
        total++; if (gap) begin bad++; $display("FAIL basic_consecutive accept cycles not back to back"); end
        total++; if (first_valid_edge - start_edge != 3) begin bad++; $display("FAIL basic_latency got=%0d required=3", first_valid_edge - start_edge); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL basic_done_count got=%0d required=1", done_cnt); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_after got=%b required=0", busy); end
    endtask

    task automatic test_backpressure();
        bit ok; int d;
        fill_linear();
        run_req(5, 4, 1, -1, ok);
        total++; if (!ok) begin bad++; $display("FAIL bp_timeout done never seen"); end
        d = first_diff();
        total++; if (d >= 0) begin bad++; $display("FAIL bp_data n=%0d required n=%0d at idx %0d", got_q.size(), exp_q.size(), d); end
        total++; if (stab_err != 0) begin bad++; $display("FAIL bp_hold unstable=%0d required=0", stab_err); end
    endtask

    task automatic test_stall();
        bit ok; int d;
        fill_linear();
        run_req(3, 1, 3, -1, ok);
        total++; if (!ok) begin bad++; $display("FAIL stall_timeout done never seen"); end
        d = first_diff();
        total++; if (d >= 0) begin bad++; $display("FAIL stall_data n=%0d required n=%0d at idx %0d", got_q.size(), exp_q.size(), d); end
        total++; if (max_out != 2) begin bad++; $display("FAIL stall_outstanding got=%0d required=2", max_out); end
        total++; if (rd_total != 3) begin bad++; $display("FAIL stall_reads got=%0d required=3", rd_total); end
    endtask

    task automatic test_zero_len();
        bit ok;
        run_req(0, 7, 0, -1, ok);
        total++; if (!ok) begin bad++; $display("FAIL zero_timeout done never seen"); end
        total++; if (rd_total != 0) begin bad++; $display("FAIL zero_reads got=%0d required=0", rd_total); end
        total++; if (done_edge - start_edge != 2) begin bad++; $display("FAIL zero_done_delay got=%0d required=2", done_edge - start_edge); end
    endtask

    task automatic test_ignore_start();
        bit ok; int d;
        fill_linear();
        run_req(6, 3, 0, 3, ok);
        total++; if (!ok) begin bad++; $display("FAIL ignore_timeout done never seen"); end
        d = first_diff();
        total++; if (d >= 0) begin bad++; $display("FAIL ignore_data n=%0d required n=%0d at idx %0d", got_q.size(), exp_q.size(), d); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL ignore_done_count got=%0d required=1", done_cnt); end
    endtask

    task automatic test_reset_mid();
        bit ok; bit hit; int d;
        fill_linear();
        clear_mon();
        @(posedge clk); #1;
        size_x = 5'd8; size_y = 5'd3; start = 1'b1; ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk); #1;
            if (got_q.size() >= 2) begin hit = 1'b1; break; end
        end
        total++; if (!hit) begin bad++; $display("FAIL rstmid_timeout outputs=%0d required>=2", got_q.size()); end
        rst = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({memz_rd, memz_addr, dout, dout_valid, busy, done} !== '0) begin
            bad++;
            $display("FAIL rstmid_outputs rd=%b addr=%0d dout=%0d v=%b busy=%b done=%b required all 0",
                     memz_rd, memz_addr, dout, dout_valid, busy, done);
        end
        rst = 1'b0;
        run_req(2, 2, 0, -1, ok);
        total++; if (!ok) begin bad++; $display("FAIL rstmid_restart_timeout done never seen"); end
        d = first_diff();
        total++; if (d >= 0) begin bad++; $display("FAIL rstmid_restart_data n=%0d required n=%0d at idx %0d", got_q.size(), exp_q.size(), d); end
    endtask

    task automatic test_random();
        bit ok; int d; int sx; int sy;
        for (int it = 0; it < 25; it++) begin
            for (int i = 0; i < 64; i++) mem[i] = 16'($urandom);
            sx = (it == 0) ? 31 : int'($urandom_range(0, 31));
            sy = (it == 0) ? 31 : (it == 1) ? 0 : int'($urandom_range(0, 31));
            run_req(sx, sy, 2, -1, ok);
            total++; if (!ok) begin bad++; $display("FAIL rand_timeout it=%0d sx=%0d sy=%0d", it, sx, sy); end
            d = first_diff();
            total++;
            if (d >= 0) begin
                bad++;
                $display("FAIL rand_data it=%0d sx=%0d sy=%0d n=%0d required n=%0d idx=%0d", it, sx, sy, got_q.size(), exp_q.size(), d);
            end
            d = first_addr_diff();
            total++; if (d >= 0) begin bad++; $display("FAIL rand_addr it=%0d n=%0d required n=%0d idx=%0d", it, rd_addr_q.size(), exp_addr_q.size(), d); end
            total++; if (stab_err != 0) begin bad++; $display("FAIL rand_hold it=%0d unstable=%0d required=0", it, stab_err); end
            total++; if (max_out > 2) begin bad++; $display("FAIL rand_outstanding it=%0d got=%0d required<=2", it, max_out); end
            total++; if (done_cnt != 1) begin bad++; $display("FAIL rand_done_count it=%0d got=%0d required=1", it, done_cnt); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_stall();
        test_zero_len();
        test_ignore_start();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
